// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_channel_decoder
// Brief    : One TMDS lane receiver. Finds the word boundary by hunting control tokens,
//            then decodes each aligned symbol to pixel data or control bits.
// Revision : 1.0
// ============================================================================
module tmds_channel_decoder #(
    parameter int SEARCH_DWELL   = 1024,
    parameter int LOCK_COUNT     = 16,
    parameter int UNLOCK_TIMEOUT = 2048
) (
    input  logic       pxl_clk_i,
    input  logic       rst_i,
    input  logic [9:0] sym_in_i,
    output logic [7:0] d_o,
    output logic       de_o,
    output logic [1:0] c_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int DWELL_W = (SEARCH_DWELL > 1) ? $clog2(SEARCH_DWELL) : 1;
    localparam int RUN_W   = $clog2(LOCK_COUNT + 1);
    localparam int TO_W    = $clog2(UNLOCK_TIMEOUT + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_DWELL - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_COUNT - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(UNLOCK_TIMEOUT - 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [9:0]         s1_q, s0_q;
    logic [9:0]         w2_q;
    logic               tok2_q;
    logic [1:0]         ctl2_q;
    logic [1:0]         state_q, state_d;
    logic [3:0]         offset_q, offset_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [1:0]         settle_q, settle_d;
    logic               locked_q;
    logic [7:0]         d_q, d_d;
    logic               de_q, de_d;
    logic [1:0]         c_q, c_d;

    logic [19:0] w_window;
    logic [9:0]  w_word;
    logic        w_tok;
    logic [1:0]  w_ctl;
    logic [7:0]  w_q;
    logic [7:0]  w_x;
    logic [7:0]  w_dec;
    logic [3:0]  w_off_adv;
    logic        w_settling;
    logic        w_locked_d;

    // s0 holds the older symbol, so bit 0 of the window is the earliest bit on the wire.
    assign w_window = {s1_q, s0_q};
    assign w_word   = 10'(w_window >> offset_q);

    always_comb begin
        w_tok = 1'b1;
        w_ctl = 2'b00;
        case (w_word)
            10'b1101010100: w_ctl = 2'b00;
            10'b0010101011: w_ctl = 2'b01;
            10'b0101010100: w_ctl = 2'b10;
            10'b1010101011: w_ctl = 2'b11;
            default:        w_tok = 1'b0;
        endcase
    end

    assign w_q   = w2_q[9] ? ~w2_q[7:0] : w2_q[7:0];
    assign w_x   = w_q ^ {w_q[6:0], 1'b0};
    assign w_dec = {w_x[7:1] ^ {7{~w2_q[8]}}, w_q[0]};

    assign w_off_adv  = (offset_q >= 4'd9) ? 4'd0 : offset_q + 4'd1;
    assign w_settling = (settle_q != 2'd0);

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        dwell_d  = dwell_q;
        run_d    = run_q;
        to_d     = to_q;
        settle_d = w_settling ? settle_q - 2'd1 : 2'd0;
        case (state_q)
            ST_SEARCH: begin
                if (!w_settling && tok2_q) begin
                    dwell_d = '0;
                    run_d   = RUN_W'(1);
                    to_d    = '0;
                    state_d = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_VERIFY;
                end else if (dwell_q >= DWELL_LAST) begin
                    offset_d = w_off_adv;
                    dwell_d  = '0;
                    settle_d = 2'd2;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            ST_VERIFY: begin
                if (!w_settling) begin
                    if (tok2_q) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_q >= RUN_LAST) begin
                            state_d = ST_LOCKED;
                            to_d    = '0;
                        end
                    end else begin
                        // A single data word during verification means a false token hit.
                        state_d  = ST_SEARCH;
                        offset_d = w_off_adv;
                        dwell_d  = '0;
                        run_d    = '0;
                        settle_d = 2'd2;
                    end
                end
            end
            ST_LOCKED: begin
                if (tok2_q) begin
                    to_d = '0;
                end else if (to_q >= TO_LAST) begin
                    state_d = ST_SEARCH;
                    to_d    = '0;
                    dwell_d = '0;
                    run_d   = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                offset_d = 4'd0;
                dwell_d  = '0;
                run_d    = '0;
                to_d     = '0;
                settle_d = 2'd0;
            end
        endcase
    end

    // Gating on the next lock state lets the outputs go idle on the very edge lock drops.
    assign w_locked_d = (state_d == ST_LOCKED);

    always_comb begin
        d_d  = 8'h00;
        de_d = 1'b0;
        c_d  = 2'b00;
        if (w_locked_d) begin
            if (tok2_q) begin
                c_d = ctl2_q;
            end else begin
                de_d = 1'b1;
                d_d  = w_dec;
            end
        end
    end

    always_ff @(posedge pxl_clk_i) begin
        if (rst_i) begin
            s1_q     <= '0;
            s0_q     <= '0;
            w2_q     <= '0;
            tok2_q   <= 1'b0;
            ctl2_q   <= 2'b00;
            state_q  <= ST_SEARCH;
            offset_q <= 4'd0;
            dwell_q  <= '0;
            run_q    <= '0;
            to_q     <= '0;
            settle_q <= 2'd0;
            locked_q <= 1'b0;
            d_q      <= 8'h00;
            de_q     <= 1'b0;
            c_q      <= 2'b00;
        end else begin
            s1_q     <= sym_in_i;
            s0_q     <= s1_q;
            w2_q     <= w_word;
            tok2_q   <= w_tok;
            ctl2_q   <= w_ctl;
            state_q  <= state_d;
            offset_q <= offset_d;
            dwell_q  <= dwell_d;
            run_q    <= run_d;
            to_q     <= to_d;
            settle_q <= settle_d;
            locked_q <= w_locked_d;
            d_q      <= d_d;
            de_q     <= de_d;
            c_q      <= c_d;
        end
    end

    assign d_o      = d_q;
    assign de_o     = de_q;
    assign c_o      = c_q;
    assign locked_o = locked_q;
    assign offset_o = offset_q;

endmodule

`default_nettype wire
